// File: rtl/uart_tx_queue.sv
// Byte FIFO and send sequencer feeding the UART transmitter.
// Optional: define UART_TXQ_THRESH_IRQ_EN to add the thresh input and irq_thresh output.
module uart_tx_queue #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_ovf,
    input  logic              tx_active,
    input  logic              tx_done,
`ifdef UART_TXQ_THRESH_IRQ_EN
    input  logic [CNT_W-1:0]  thresh,
    output logic              irq_thresh,
`endif
    output logic              tx_send,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);
    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push  = wr_en && !full;
    assign pop   = (state == IDLE) && !empty;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (!empty) next_state = LOAD;
            LOAD:      next_state = SEND;
            SEND:      if (tx_active) next_state = WAIT_DONE;
            WAIT_DONE: if (tx_done && !tx_active) next_state = GAP;
            GAP:       next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // tx_send is a level held for the whole SEND state; the transmitter samples it on its baud tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
        end else begin
            state   <= next_state;
            tx_send <= (next_state == SEND);
            if (pop) tx_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
            else if (clr_ovf)  overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) mem[wr_ptr] <= wr_data;
    end

`ifdef UART_TXQ_THRESH_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) irq_thresh <= 1'b0;
        else       irq_thresh <= (count <= thresh) && (state == IDLE);
    end
`endif

endmodule
